// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encodings and the
// read value returned on a forced (timed-out) completion.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between a CPU (M0) and a DMA (M1).
// Define BUS_ARBITER_TIMEOUT_EN to force-complete grants after TIMEOUT_CYCLES.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t next_state;
    logic   last_owner;
    logic   timeout_hit;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_count;

    // Held at zero in IDLE so every grant starts counting from zero.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wait_count <= '0;
        end else if (state == IDLE || i_bus_ready) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + 1'b1;
        end
    end

    assign timeout_hit = (state != IDLE) && (wait_count == LAST_WAIT);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= next_state;
            if (i_bus_ready || timeout_hit) begin
                if (state == GRANT_M0) last_owner <= 1'b0;
                if (state == GRANT_M1) last_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_m0_request && i_m1_request) begin
                    next_state = last_owner ? GRANT_M0 : GRANT_M1;
                end else if (i_m0_request) begin
                    next_state = GRANT_M0;
                end else if (i_m1_request) begin
                    next_state = GRANT_M1;
                end
            end
            GRANT_M0: begin
                if (!i_m0_request || i_bus_ready || timeout_hit) next_state = IDLE;
            end
            GRANT_M1: begin
                if (!i_m1_request || i_bus_ready || timeout_hit) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant-side muxing is purely combinational so a same-cycle slave ready
    // completes the transaction in its first grant cycle.
    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_m0_ready    = 1'b0;
        o_m0_rdata    = '0;
        o_m1_ready    = 1'b0;
        o_m1_rdata    = '0;
        case (state)
            GRANT_M0: begin
                o_bus_request = i_m0_request;
                o_bus_rw      = i_m0_rw;
                o_bus_address = i_m0_address;
                o_bus_wdata   = i_m0_wdata;
                o_m0_ready    = i_bus_ready || timeout_hit;
                o_m0_rdata    = (timeout_hit && !i_bus_ready) ? TIMEOUT_RDATA : i_bus_rdata;
            end
            GRANT_M1: begin
                o_bus_request = i_m1_request;
                o_bus_rw      = i_m1_rw;
                o_bus_address = i_m1_address;
                o_bus_wdata   = i_m1_wdata;
                o_m1_ready    = i_bus_ready || timeout_hit;
                o_m1_rdata    = (timeout_hit && !i_bus_ready) ? TIMEOUT_RDATA : i_bus_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for fairness, stalls, async reset and timeout.
module tb_bus_arbiter;

    typedef struct packed {
        logic        m0_req;
        logic        m0_rw;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_rw;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        bus_ready;
        logic [31:0] bus_rdata;
    } in_t;

    typedef struct packed {
        logic        bus_req;
        logic        bus_rw;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic        m0_ready;
        logic [31:0] m0_rdata;
        logic        m1_ready;
        logic [31:0] m1_rdata;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_rw, m1_req, m1_rw, bus_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        o_m0_ready, o_m1_ready, o_bus_request, o_bus_rw;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_bus_address, o_bus_wdata;
    out_t        act;

    int n_cmp;
    int n_bad;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_m0_request (m0_req),
        .i_m0_rw      (m0_rw),
        .i_m0_address (m0_addr),
        .i_m0_wdata   (m0_wdata),
        .o_m0_ready   (o_m0_ready),
        .o_m0_rdata   (o_m0_rdata),
        .i_m1_request (m1_req),
        .i_m1_rw      (m1_rw),
        .i_m1_address (m1_addr),
        .i_m1_wdata   (m1_wdata),
        .o_m1_ready   (o_m1_ready),
        .o_m1_rdata   (o_m1_rdata),
        .o_bus_request(o_bus_request),
        .o_bus_rw     (o_bus_rw),
        .o_bus_address(o_bus_address),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ready  (bus_ready),
        .i_bus_rdata  (bus_rdata)
    );

    assign act = {o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
                  o_m0_ready, o_m0_rdata, o_m1_ready, o_m1_rdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic apply(input in_t v);
        m0_req    = v.m0_req;
        m0_rw     = v.m0_rw;
        m0_addr   = v.m0_addr;
        m0_wdata  = v.m0_wdata;
        m1_req    = v.m1_req;
        m1_rw     = v.m1_rw;
        m1_addr   = v.m1_addr;
        m1_wdata  = v.m1_wdata;
        bus_ready = v.bus_ready;
        bus_rdata = v.bus_rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('0);
        tick();
        rst = 1'b0;
    endtask

    localparam logic [31:0] A0 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'hA5A5_0001;
    localparam logic [31:0] A1 = 32'h0000_3000;
    localparam logic [31:0] W1 = 32'h1111_1111;

    vec_t vecs[13];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        apply('0);

        vecs[0]  = '{stim: '0, exp: '0};
        vecs[1]  = '{stim: '{1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF},
                     exp: '0};
        vecs[2]  = '{stim: '{1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF},
                     exp: '{1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}};
        vecs[3]  = '{stim: '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF},
                     exp: '0};
        vecs[4]  = '{stim: '{1'b1, 1'b1, A0, W0, 1'b1, 1'b0, A1, W1, 1'b0, 32'h55AA_55AA},
                     exp: '0};
        vecs[5]  = '{stim: '{1'b1, 1'b1, A0, W0, 1'b1, 1'b0, A1, W1, 1'b0, 32'h55AA_55AA},
                     exp: '{1'b1, 1'b0, A1, W1, 1'b0, 32'h0, 1'b0, 32'h55AA_55AA}};
        vecs[6]  = '{stim: '{1'b1, 1'b1, A0, W0, 1'b1, 1'b0, A1, W1, 1'b1, 32'h0BAD_CAFE},
                     exp: '{1'b1, 1'b0, A1, W1, 1'b0, 32'h0, 1'b1, 32'h0BAD_CAFE}};
        vecs[7]  = '{stim: '{1'b1, 1'b1, A0, W0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BAD_CAFE},
                     exp: '0};
        vecs[8]  = '{stim: '{1'b1, 1'b1, A0, W0, 1'b1, 1'b1, A1, W1, 1'b0, 32'h0000_0077},
                     exp: '{1'b1, 1'b1, A0, W0, 1'b0, 32'h0000_0077, 1'b0, 32'h0}};
        vecs[9]  = '{stim: '{1'b0, 1'b1, A0, W0, 1'b1, 1'b1, A1, W1, 1'b0, 32'h0000_0077},
                     exp: '{1'b0, 1'b1, A0, W0, 1'b0, 32'h0000_0077, 1'b0, 32'h0}};
        vecs[10] = '{stim: '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, A1, W1, 1'b0, 32'h0},
                     exp: '0};
        vecs[11] = '{stim: '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, A1, W1, 1'b1, 32'h600D_F00D},
                     exp: '{1'b1, 1'b1, A1, W1, 1'b0, 32'h0, 1'b1, 32'h600D_F00D}};
        vecs[12] = '{stim: '0, exp: '0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", act, '0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].stim);
            #1;
            check($sformatf("vec%0d", i), act, vecs[i].exp);
            tick();
        end

        // Both masters held with a zero-wait slave: grants must alternate, M0 first.
        do_reset();
        apply('{1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 32'hC0DE_0000});
        for (int c = 0; c < 12; c++) begin
            logic [34:0] want;
            #1;
            if (c % 2 == 0) want = '0;
            else if ((c / 2) % 2 == 0) want = {1'b1, 32'h0000_0100, 1'b1, 1'b0};
            else want = {1'b1, 32'h0000_0200, 1'b0, 1'b1};
            check($sformatf("fair_cycle%0d", c),
                  {97'h0, o_bus_request, o_bus_address, o_m0_ready, o_m1_ready}, {97'h0, want});
            tick();
        end

        // M1 write stalled by a slow slave while M0 waits behind it.
        do_reset();
        apply('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 32'h0});
        tick();
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0044;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall_cycle%0d", k),
                  {62'h0, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_m0_ready, o_m1_ready},
                  {62'h0, 1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 1'b0});
            tick();
        end
        bus_ready = 1'b1;
        #1;
        check("stall_done", {130'h0, o_m0_ready, o_m1_ready}, {130'h0, 1'b0, 1'b1});
        tick();
        m1_req    = 1'b0;
        bus_ready = 1'b0;
        #1;
        check("stall_gap", act, '0);
        tick();
        #1;
        check("stall_m0_next", {98'h0, o_bus_request, o_bus_rw, o_bus_address},
              {98'h0, 1'b1, 1'b0, 32'h0000_0044});

        // Asynchronous reset in the middle of an M1 grant.
        do_reset();
        apply('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0088, 32'h0, 1'b0, 32'h0});
        tick();
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0099;
        #1;
        check("rst_pre_grant", {99'h0, o_bus_request, o_bus_address}, {99'h0, 1'b1, 32'h0000_0088});
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", act, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        check("rst_m0_first", {99'h0, o_bus_request, o_bus_address}, {99'h0, 1'b1, 32'h0000_0099});

        // Slave never answers an M0 read.
        do_reset();
        apply('{1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1234_5678});
        tick();
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("timeout_cycle%0d", k), {98'h0, o_bus_request, o_m0_ready, o_m0_rdata},
                  (k < 8) ? {98'h0, 1'b1, 1'b0, 32'h1234_5678} : {98'h0, 1'b1, 1'b1, 32'hFFFF_FFFF});
            tick();
        end
        #1;
        check("timeout_idle", act, '0);
`else
        begin
            int held;
            held = 0;
            for (int k = 0; k < 110; k++) begin
                if (o_bus_request && !o_m0_ready && o_bus_address == 32'h0000_1234) held++;
                tick();
            end
            check("grant_persists", 132'(held), 132'd110);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
